// File: rtl/fp16_normalizer.sv
// fp16_normalizer: post-add normalize and pack to binary16; define FP16_NORM_ROUND_EN to round-half-even on carry shift
module fp16_normalizer #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W+1:0]       in_mant,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   flag_zero,
  output logic                   flag_ovf,
  output logic                   flag_unf
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EONE = (EXP_W+1)'(1);
  state_t                 state_q, state_d;
  logic                   s_q, s_d;
  logic [EXP_W:0]         e_q, e_d, e_inc;
  logic [MAN_W+1:0]       m_q, m_d;
  logic [EXP_W+MAN_W:0]   result_q, result_d;
  logic                   zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d, valid_q, valid_d;
  assign in_ready  = state_q == IDLE;
  assign out_valid = valid_q;
  assign result    = result_q;
  assign flag_zero = zero_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;
  assign e_inc     = e_q + EONE;
  // one normalization step per cycle, results registered on entry to DONE
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    e_d      = e_q;
    m_d      = m_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: if (in_valid) begin
        s_d     = in_sign;
        e_d     = {1'b0, in_exp};
        m_d     = in_mant;
        state_d = NORM;
      end
      NORM: begin
        if (m_q == '0) begin
          result_d = {s_q, {(EXP_W+MAN_W){1'b0}}};
          zero_d   = 1'b1;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else if (m_q[MAN_W+1]) begin
`ifdef FP16_NORM_ROUND_EN
          m_d = (m_q >> 1) + {{(MAN_W+1){1'b0}}, m_q[1] & m_q[0]};
`else
          m_d = m_q >> 1;
`endif
          e_d = e_inc;
          if (e_inc >= EMAX) begin
            result_d = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_d    = 1'b1;
            valid_d  = 1'b1;
            state_d  = DONE;
          end
        end else if (m_q[MAN_W]) begin
          result_d = {s_q, e_q[EXP_W-1:0], m_q[MAN_W-1:0]};
          valid_d  = 1'b1;
          state_d  = DONE;
        end else if (e_q <= EONE) begin
          result_d = {s_q, {(EXP_W+MAN_W){1'b0}}};
          unf_d    = 1'b1;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else begin
          m_d = m_q << 1;
          e_d = e_q - EONE;
        end
      end
      DONE: if (out_ready) begin
        valid_d = 1'b0;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously so reset aborts any operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= 1'b0;
      e_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      e_q      <= e_d;
      m_q      <= m_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= valid_d;
    end
  end
endmodule

// File: tb/tb_fp16_normalizer.sv
// tb_fp16_normalizer: scoreboard bench for the binary16 post-add normalizer
module tb_fp16_normalizer;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, in_sign = 0, out_valid, out_ready = 1;
  logic flag_zero, flag_ovf, flag_unf;
  logic [4:0] in_exp = 0;
  logic [11:0] in_mant = 0;
  logic [15:0] result;
  int errors = 0, checks = 0;
  typedef struct { logic [15:0] r; logic [2:0] f; int lat; } exp_t;
  exp_t sb[$];

  fp16_normalizer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_zero(flag_zero), .flag_ovf(flag_ovf), .flag_unf(flag_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic void model(input logic s, input logic [4:0] ex, input logic [11:0] mi,
                                output logic [15:0] r, output logic [2:0] f, output int lat);
    int e = ex;
    logic [11:0] m = mi;
    logic drop;
    lat = 0;
    f = 3'b000;
    r = 16'h0;
    for (int k = 0; k < 40; k++) begin
      lat++;
      if (m == 0) begin r = {s, 15'h0}; f = 3'b100; return; end
      if (m[11]) begin
        drop = m[0];
        m = m >> 1;
        e = e + 1;
`ifdef FP16_NORM_ROUND_EN
        if (drop && m[0]) m = m + 1;
`endif
        if (e >= 31) begin r = {s, 5'h1F, 10'h0}; f = 3'b010; return; end
      end else if (m[10]) begin
        r = {s, 5'(e), m[9:0]}; return;
      end else if (e <= 1) begin
        r = {s, 15'h0}; f = 3'b001; return;
      end else begin
        m = m << 1;
        e = e - 1;
      end
    end
  endfunction

  task automatic issue(input logic s, input logic [4:0] e, input logic [11:0] m, input bit push,
                       input logic [15:0] r, input logic [2:0] f, input int lat);
    int n = 0;
    exp_t x;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", in_ready, 1);
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    if (push) begin x.r = r; x.f = f; x.lat = lat; sb.push_back(x); end
  endtask

  task automatic collect(input string tag);
    int n = 0;
    exp_t x;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_valid"}, out_valid, 1);
    x = sb.pop_front();
    chk({tag, "_lat"}, n, x.lat);
    chk({tag, "_result"}, result, x.r);
    chk({tag, "_flags"}, {flag_zero, flag_ovf, flag_unf}, x.f);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_drop"}, {out_valid, in_ready}, 2'b01);
    end
  endtask

  task automatic run(input string tag, input logic s, input logic [4:0] e, input logic [11:0] m,
                     input logic [15:0] r, input logic [2:0] f, input int lat);
    issue(s, e, m, 1, r, f, lat);
    collect(tag);
  endtask

  initial begin
    logic [15:0] r, held;
    logic [2:0] f;
    int lat;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_state", {out_valid, in_ready, flag_zero, flag_ovf, flag_unf}, 5'b01000);
    chk("rst_result", result, 16'h0000);

    run("carry", 0, 15, 12'hC00, 16'h4200, 3'b000, 2);
`ifdef FP16_NORM_ROUND_EN
    run("carry_rnd", 0, 15, 12'hC03, 16'h4202, 3'b000, 2);
`else
    run("carry_trunc", 0, 15, 12'hC03, 16'h4201, 3'b000, 2);
`endif
    run("left2", 0, 15, 12'h100, 16'h3400, 3'b000, 3);
    run("norm", 0, 15, 12'h400, 16'h3C00, 3'b000, 1);
    run("zero", 1, 15, 12'h000, 16'h8000, 3'b100, 1);
    run("ovf", 0, 30, 12'h800, 16'h7C00, 3'b010, 1);
    run("unf", 0, 2, 12'h080, 16'h0000, 3'b001, 2);
    run("worst", 0, 20, 12'h001, 16'h2800, 3'b000, 11);
    run("exp0", 1, 0, 12'h400, 16'h8000, 3'b000, 1);
    run("exp0_unf", 0, 0, 12'h200, 16'h0000, 3'b001, 1);

    out_ready = 0;
    issue(1, 15, 12'hC00, 1, 16'hC200, 3'b000, 2);
    collect("bp");
    held = result;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_mant = 12'h000;
      @(posedge clk); #1;
      in_valid = 0;
      chk("bp_hold", {out_valid, in_ready, flag_zero, flag_ovf, flag_unf}, 5'b10000);
      chk("bp_result", result, held);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    chk("bp_keep", result, held);
    run("bp_next", 0, 15, 12'h400, 16'h3C00, 3'b000, 1);

    issue(0, 20, 12'h001, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_state", {out_valid, in_ready}, 2'b01);
    chk("abort_result", result, 16'h0000);
    @(posedge clk); #1 rst_n = 1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin @(posedge clk); #1; seen |= out_valid; end
    chk("abort_no_valid", seen, 0);

    for (int i = 0; i < 20; i++) begin
      logic s;
      logic [4:0] e;
      logic [11:0] m;
      s = 1'($urandom);
      e = 5'($urandom_range(0, 31));
      m = (i % 4 == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom);
      model(s, e, m, r, f, lat);
      run("rand", s, e, m, r, f, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
